// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory-port arbiter, the core and the memory model.
package mem_port_arbiter_pkg;

    // Legacy state encodings; the enum below is built on them so both views agree.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ_IF  = 3'd1;
    localparam logic [2:0] S_REQ_DM  = 3'd2;
    localparam logic [2:0] S_WAIT_IF = 3'd3;
    localparam logic [2:0] S_WAIT_DM = 3'd4;

    typedef enum logic [2:0] {
        ARB_IDLE    = S_IDLE,
        ARB_REQ_IF  = S_REQ_IF,
        ARB_REQ_DM  = S_REQ_DM,
        ARB_WAIT_IF = S_WAIT_IF,
        ARB_WAIT_DM = S_WAIT_DM
    } arb_state_t;

    localparam int unsigned PKG_AW = 32;
    localparam int unsigned PKG_DW = 32;

    // One memory request as seen on the unified port.
    typedef struct packed {
        logic                  we;
        logic [PKG_DW/8-1:0]   be;
        logic [PKG_AW-1:0]     addr;
        logic [PKG_DW-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side (fetch + data) and memory-side handshake signals.
// master: the arbiter. slave: the environment (core requesters and memory).
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // instruction fetch requester
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    // data requester
    logic            dm_req;
    logic            dm_we;
    logic [DW/8-1:0] dm_be;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [DW-1:0]   dm_rdata;

    // unified memory port
    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (IF) and data (DM).
// DM wins ties unless it has been granted MAX_DM_STREAK times in a row while IF waited.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    mem_port_arbiter_if.master bus,
    output logic               PROTO_ERR
);

    localparam int unsigned     SW         = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DM_STREAK);

    arb_state_t      state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            proto_err_q, proto_err_d;

    logic            any_req;
    arb_state_t      pick_state;

    logic            sel_req;
    logic            sel_we;
    logic [DW/8-1:0] sel_be;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // Pick rule: DM over IF, except IF once the DM streak has hit the cap.
    always_comb begin
        any_req    = bus.if_req | bus.dm_req;
        pick_state = ARB_REQ_DM;
        if (bus.if_req && (!bus.dm_req || (streak_q == STREAK_MAX))) begin
            pick_state = ARB_REQ_IF;
        end
    end

    // Memory-port mux: only the owner in REQ_x drives MEM_*, everything else reads as 0.
    always_comb begin
        sel_req   = 1'b0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (state_q == ARB_REQ_IF) begin
            sel_req  = 1'b1;
            sel_be   = '1;
            sel_addr = bus.if_addr;
        end else if (state_q == ARB_REQ_DM) begin
            sel_req   = 1'b1;
            sel_we    = bus.dm_we;
            sel_be    = bus.dm_be;
            sel_addr  = bus.dm_addr;
            sel_wdata = bus.dm_wdata;
        end
    end

    assign bus.mem_req   = sel_req;
    assign bus.mem_we    = sel_we;
    assign bus.mem_be    = sel_be;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
    assign PROTO_ERR     = proto_err_q;

    // FSM next state, streak update, handshake pulses and protocol-error detection.
    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        proto_err_d   = proto_err_q;
        bus.if_gnt    = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.dm_rvalid = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.mem_rvalid) proto_err_d = 1'b1;
                if (any_req) state_d = pick_state;
            end
            ARB_REQ_IF: begin
                // a response alongside the grant is a zero-latency reply: flagged and dropped
                if (bus.mem_rvalid) proto_err_d = 1'b1;
                if (bus.mem_gnt) begin
                    bus.if_gnt = 1'b1;
                    streak_d   = '0;
                    state_d    = ARB_WAIT_IF;
                end
            end
            ARB_REQ_DM: begin
                if (bus.mem_rvalid) proto_err_d = 1'b1;
                if (bus.mem_gnt) begin
                    bus.dm_gnt = 1'b1;
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                    state_d = ARB_WAIT_DM;
                end
            end
            ARB_WAIT_IF: begin
                if (bus.mem_rvalid) begin
                    bus.if_rvalid = 1'b1;
                    state_d       = any_req ? pick_state : ARB_IDLE;
                end
            end
            ARB_WAIT_DM: begin
                if (bus.mem_rvalid) begin
                    bus.dm_rvalid = 1'b1;
                    state_d       = any_req ? pick_state : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ARB_IDLE;
            streak_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester/memory models plus grant/response scoreboard.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic     is_dm;
        mem_req_t req;
    } gnt_exp_t;

    typedef struct {
        logic        is_dm;
        logic        chk_data;
        logic [31:0] data;
    } rsp_exp_t;

    logic CLOCK;
    logic RESET_N;
    logic PROTO_ERR;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_STREAK(4)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .bus       (bus),
        .PROTO_ERR (PROTO_ERR)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_req_t    if_src[$];
    mem_req_t    dm_src[$];
    gnt_exp_t    exp_gnt[$];
    rsp_exp_t    exp_rsp[$];

    logic        if_gnt_s = 1'b0;
    logic        dm_gnt_s = 1'b0;
    int unsigned gnt_lat  = 1;
    int unsigned rv_lat   = 1;
    int unsigned inj_req  = 0;
    int unsigned kill_req = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ((a ^ 32'h100) * 32'h0001_0003) ^ 32'hDEADBEEF;
    endfunction

    function automatic mem_req_t mk_req(input logic we, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        mem_req_t r;
        r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic src_if(input logic [31:0] addr);
        if_src.push_back(mk_req(1'b0, 4'hF, addr, 32'h0));
    endtask

    task automatic src_dm(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        dm_src.push_back(mk_req(we, be, addr, wdata));
    endtask

    task automatic exp_if(input logic [31:0] addr);
        gnt_exp_t e;
        e.is_dm = 1'b0;
        e.req   = mk_req(1'b0, 4'hF, addr, 32'h0);
        exp_gnt.push_back(e);
    endtask

    task automatic exp_dm(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        gnt_exp_t e;
        e.is_dm = 1'b1;
        e.req   = mk_req(we, be, addr, wdata);
        exp_gnt.push_back(e);
    endtask

    // Requester and memory models; all drive changes happen 1 time unit after the rising edge.
    initial begin
        int unsigned age     = 0;
        int unsigned rv_cnt  = 0;
        int unsigned inj_ack = 0;
        int unsigned kill_ack = 0;
        logic [31:0] lat_addr = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (bus.if_req && if_gnt_s) begin
                void'(if_src.pop_front());
                bus.if_req = 1'b0;
            end
            if (!bus.if_req && if_src.size() > 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = if_src[0].addr;
            end
            if (bus.dm_req && dm_gnt_s) begin
                void'(dm_src.pop_front());
                bus.dm_req = 1'b0;
            end
            if (!bus.dm_req && dm_src.size() > 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = dm_src[0].we;
                bus.dm_be    = dm_src[0].be;
                bus.dm_addr  = dm_src[0].addr;
                bus.dm_wdata = dm_src[0].wdata;
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (kill_req != kill_ack) begin
                kill_ack++;
                rv_cnt = 0;
            end
            if (inj_req != inj_ack) begin
                inj_ack++;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h0BAD_0BAD;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_data(lat_addr);
                end
            end
            if (bus.mem_req) begin
                age++;
                if (age >= gnt_lat) begin
                    bus.mem_gnt = 1'b1;
                    lat_addr    = bus.mem_addr;
                    rv_cnt      = rv_lat;
                    age         = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        gnt_exp_t e;
        rsp_exp_t r;
        forever begin
            @(negedge CLOCK);
            if_gnt_s = bus.if_gnt;
            dm_gnt_s = bus.dm_gnt;
            if (RESET_N) begin
                if (bus.mem_req && bus.mem_gnt) begin
                    if (exp_gnt.size() == 0) begin
                        check("gnt_unexpected", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_gnt.pop_front();
                        check("gnt_dm", 64'(bus.dm_gnt), 64'(e.is_dm));
                        check("gnt_if", 64'(bus.if_gnt), 64'(!e.is_dm));
                        check("mem_addr", 64'(bus.mem_addr), 64'(e.req.addr));
                        check("mem_we", 64'(bus.mem_we), 64'(e.req.we));
                        check("mem_be", 64'(bus.mem_be), 64'(e.req.be));
                        check("mem_wdata", 64'(bus.mem_wdata), 64'(e.req.wdata));
                        r.is_dm    = e.is_dm;
                        r.chk_data = !e.req.we;
                        r.data     = mem_data(e.req.addr);
                        exp_rsp.push_back(r);
                    end
                end else begin
                    check("gnt_spurious", 64'({bus.if_gnt, bus.dm_gnt}), 64'd0);
                end
                if (bus.if_rvalid || bus.dm_rvalid) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_dm", 64'(bus.dm_rvalid), 64'(r.is_dm));
                        check("rsp_if", 64'(bus.if_rvalid), 64'(!r.is_dm));
                        if (r.chk_data) begin
                            check("rdata", 64'(r.is_dm ? bus.dm_rdata : bus.if_rdata), 64'(r.data));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge CLOCK);
        #1;
    endtask

    // which: 0 if_gnt, 1 dm_gnt, 2 if_rvalid, 3 dm_rvalid
    task automatic wait_for(input string tag, input int unsigned which);
        logic seen = 1'b0;
        for (int unsigned n = 0; n < 40 && !seen; n++) begin
            step();
            case (which)
                0: seen = bus.if_gnt;
                1: seen = bus.dm_gnt;
                2: seen = bus.if_rvalid;
                default: seen = bus.dm_rvalid;
            endcase
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((if_src.size() + dm_src.size() + exp_gnt.size() + exp_rsp.size()) != 0 && n < 400) begin
            step();
            n++;
        end
        check(tag, 64'(n < 400), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 64'({bus.mem_req, bus.mem_we, bus.mem_be, bus.if_gnt, bus.if_rvalid,
                        bus.dm_gnt, bus.dm_rvalid, PROTO_ERR}), 64'd0);
        check({tag, "_addr"}, 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
    endtask

    initial begin
        int unsigned d;
        int unsigned f;
        logic seen;
        RESET_N = 1'b0;
        step();
        step();
        check_quiet("reset_outputs");
        RESET_N = 1'b1;
        step();
        check_quiet("idle_outputs");

        // 1: single fetch, grant on cycle 2, response 2 cycles later
        gnt_lat = 2; rv_lat = 2;
        src_if(32'h100); exp_if(32'h100);
        step();
        check("t1_c0_memreq", 64'(bus.mem_req), 64'd0);
        step();
        check("t1_c1_memreq", 64'(bus.mem_req), 64'd1);
        check("t1_c1_addr", 64'(bus.mem_addr), 64'h100);
        check("t1_c1_ifgnt", 64'(bus.if_gnt), 64'd0);
        step();
        check("t1_c2_ifgnt", 64'(bus.if_gnt), 64'd1);
        check("t1_c2_dm", 64'({bus.dm_gnt, bus.dm_rvalid}), 64'd0);
        step();
        check("t1_c3_memreq", 64'(bus.mem_req), 64'd0);
        check("t1_c3_ifrv", 64'(bus.if_rvalid), 64'd0);
        step();
        check("t1_c4_ifrv", 64'(bus.if_rvalid), 64'd1);
        check("t1_c4_rdata", 64'(bus.if_rdata), 64'hDEAD_BEEF);
        check("t1_c4_dm", 64'({bus.dm_gnt, bus.dm_rvalid}), 64'd0);
        drain("t1_drain");

        // 2: simultaneous requests, DM first, IF back-to-back after DM_RVALID
        gnt_lat = 1; rv_lat = 1;
        src_dm(1'b0, 4'hF, 32'h300, 32'h0); src_if(32'h140);
        exp_dm(1'b0, 4'hF, 32'h300, 32'h0); exp_if(32'h140);
        wait_for("t2_dm_rvalid", 3);
        step();
        check("t2_b2b_memreq", 64'(bus.mem_req), 64'd1);
        check("t2_b2b_addr", 64'(bus.mem_addr), 64'h140);
        drain("t2_drain");

        // 4: store muxing and ack
        src_dm(1'b1, 4'b0011, 32'h200, 32'h1234);
        exp_dm(1'b1, 4'b0011, 32'h200, 32'h1234);
        drain("t4_drain");

        // 3: both held high, grant order DMx4, IF, DMx4, IF, DM, DM
        for (int unsigned i = 0; i < 10; i++) src_dm(1'b0, 4'hF, 32'h1000 + 32'(4 * i), 32'h0);
        for (int unsigned i = 0; i < 2; i++) src_if(32'h2000 + 32'(4 * i));
        d = 0; f = 0;
        for (int unsigned k = 0; k < 12; k++) begin
            if ((k % 5) == 4 && f < 2) begin
                exp_if(32'h2000 + 32'(4 * f));
                f++;
            end else begin
                exp_dm(1'b0, 4'hF, 32'h1000 + 32'(4 * d), 32'h0);
                d++;
            end
        end
        drain("t3_drain");

        // 6: DM arrives while IF waits for its response
        gnt_lat = 1; rv_lat = 4;
        src_if(32'h400); exp_if(32'h400); exp_dm(1'b0, 4'hF, 32'h500, 32'h0);
        wait_for("t6_if_gnt", 0);
        src_dm(1'b0, 4'hF, 32'h500, 32'h0);
        seen = 1'b0;
        for (int unsigned n = 0; n < 10 && !seen; n++) begin
            step();
            seen = bus.if_rvalid;
            if (!seen) check("t6_hold_memreq", 64'(bus.mem_req), 64'd0);
        end
        check("t6_if_rvalid", 64'(seen), 64'd1);
        step();
        check("t6_dm_memreq", 64'(bus.mem_req), 64'd1);
        check("t6_dm_addr", 64'(bus.mem_addr), 64'h500);
        drain("t6_drain");
        check("proto_err_clean", 64'(PROTO_ERR), 64'd0);

        // 5: reset during WAIT_DM, stale response afterwards
        gnt_lat = 1; rv_lat = 8;
        src_dm(1'b0, 4'hF, 32'h600, 32'h0); exp_dm(1'b0, 4'hF, 32'h600, 32'h0);
        wait_for("t5_dm_gnt", 1);
        step();
        RESET_N = 1'b0;
        kill_req++;
        #1;
        check_quiet("t5_async_reset");
        step();
        step();
        RESET_N = 1'b1;
        exp_rsp.delete();
        inj_req++;
        step();
        check("t5_inj_rvalid", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
        check("t5_inj_perr_pre", 64'(PROTO_ERR), 64'd0);
        step();
        check("t5_perr_set", 64'(PROTO_ERR), 64'd1);
        step();
        check("t5_perr_sticky", 64'(PROTO_ERR), 64'd1);
        check("t5_no_rvalid", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
